// File: rtl/binary_search_pkg.sv
// -----------------------------------------------------------------------------
// binary_search_pkg
// Shared definitions for the binary-search controller, datapath and top level:
//   - bs_state_t      : controller state encoding (2-bit)
//   - DEFAULT_ADDR_W  : default address width (32-entry RAM)
//   - DEFAULT_DATA_W  : default RAM word / target width
// -----------------------------------------------------------------------------
package binary_search_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } bs_state_t;

endpackage

// File: rtl/binary_search_ctrl.sv
// -----------------------------------------------------------------------------
// binary_search_ctrl
// Control FSM that sequences binary_search_datapath against a sorted-ascending,
// synchronous-read RAM. The datapath midpoint M addresses the RAM directly; the
// controller waits out the read latency, compares the returned word with A and
// either narrows the bounds or terminates the search.
//
// Parameters:
//   DATA_W  RAM word / target width
//   ADDR_W  address width, must match the datapath
//   RD_LAT  RAM read latency in cycles (1..3)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   start      in   begin search (level, sampled only in IDLE)
//   A          in   target value, held stable from start until done
//   mem_data   in   RAM read data for address M
//   L, R, M    in   datapath bounds and midpoint
//   load_regs  out  initialise datapath (L=0, R=max, Loc=0, Found=0, Done=0)
//   set_Addr   out  capture M into Loc
//   set_L      out  L <= M + 1
//   set_R      out  R <= M - 1
//   set_Found  out  set Found
//   set_Done   out  set Done
//   busy       out  high while a probe is in flight (WAIT, CMP)
// -----------------------------------------------------------------------------
module binary_search_ctrl
  import binary_search_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] L,
  input  logic [ADDR_W-1:0] R,
  input  logic [ADDR_W-1:0] M,
  output logic              load_regs,
  output logic              set_Addr,
  output logic              set_L,
  output logic              set_R,
  output logic              set_Found,
  output logic              set_Done,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  bs_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_regs  = 1'b0;
    set_Addr   = 1'b0;
    set_L      = 1'b0;
    set_R      = 1'b0;
    set_Found  = 1'b0;
    set_Done   = 1'b0;
    busy       = 1'b0;

    unique case (state)
      IDLE: begin
        load_regs = 1'b1;
        if (start) begin
          state_next = WAIT;
          cnt_next   = CNT_LOAD;
        end
      end

      WAIT: begin
        // Bounds are untouched here, so M (the RAM address) is stable while
        // the read latency elapses.
        busy = 1'b1;
        if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end
        if (cnt <= CNT_ONE) begin
          state_next = CMP;
        end
      end

      CMP: begin
        busy = 1'b1;
        if (mem_data == A) begin
          set_Addr   = 1'b1;
          set_Found  = 1'b1;
          set_Done   = 1'b1;
          state_next = DONE;
        end else if (mem_data > A) begin
          // Target lies below M. At M==L there is nothing left below, and
          // M-1 would underflow at address 0.
          if (M == L) begin
            set_Done   = 1'b1;
            state_next = DONE;
          end else begin
            set_R      = 1'b1;
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end else begin
          // Target lies above M. At M==R there is nothing left above, and
          // M+1 would wrap at the top address.
          if (M == R) begin
            set_Done   = 1'b1;
            state_next = DONE;
          end else begin
            set_L      = 1'b1;
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end

      DONE: begin
        // Datapath holds its result; a new search needs start low first.
        if (!start) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Strobes stay quiet while reset is held; load_regs resumes in the first
    // cycle after release and clears any stale datapath result.
    if (reset) begin
      load_regs = 1'b0;
    end
  end

endmodule
